// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial WIDTH-bit subtractor, D = X - Y - Bin, LSB first,
//            with a start/busy/done handshake.
//            Optional signed-overflow output: define SERIAL_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [0:0]      c_IDLE  = 1'b0;
    localparam logic [0:0]      c_SHIFT = 1'b1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_d;
    logic [c_CNT_W-1:0] r_count;
    logic               r_borrow;
    logic               r_bout;
    logic               r_done;
    logic               w_last;
    logic               w_dbit;
    logic               w_bnext;
    logic [WIDTH-1:0]   w_res_next;
`ifdef SERIAL_SUB_OVF_EN
    logic               r_x_msb;
    logic               r_y_msb;
    logic               r_ovf;
`endif

    // Single full-subtractor cell working on the current LSBs.
    always_comb begin
        w_dbit     = r_x[0] ^ r_y[0] ^ r_borrow;
        w_bnext    = (~r_x[0] & r_y[0]) | (~(r_x[0] ^ r_y[0]) & r_borrow);
        w_res_next = {w_dbit, r_res[WIDTH-1:1]};
        w_last     = (r_state == c_SHIFT) && (r_count == c_LAST);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_res    <= '0;
            r_d      <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_x_msb  <= 1'b0;
            r_y_msb  <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_x      <= X;
                        r_y      <= Y;
                        r_borrow <= Bin;
                        r_count  <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        r_x_msb  <= X[WIDTH-1];
                        r_y_msb  <= Y[WIDTH-1];
`endif
                    end
                end
                c_SHIFT: begin
                    r_x      <= r_x >> 1;
                    r_y      <= r_y >> 1;
                    r_borrow <= w_bnext;
                    r_res    <= w_res_next;
                    r_count  <= r_count + 1'b1;
                    // Results are published only on the final bit so D/Bout stay stable while busy.
                    if (w_last) begin
                        r_d    <= w_res_next;
                        r_bout <= w_bnext;
                        r_done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf  <= (r_x_msb != r_y_msb) && (w_dbit != r_x_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_next_state = c_SHIFT;
            c_SHIFT: if (w_last) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        busy = (r_state == c_SHIFT);
        done = r_done;
        D    = r_d;
        Bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
        ovf  = r_ovf;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed/scoreboard bench for serial_subtractor (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int           n_checks = 0;
    int           n_fail = 0;
    exp_t         sb[$];
    logic [W-1:0] last_d = '0;
    logic         last_bout = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (x),
        .Y     (y),
        .Bin   (bin),
        .busy  (busy),
        .done  (done),
        .D     (d),
        .Bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        int   diff;
        diff   = int'(a) - int'(b) - int'(c);
        e.d    = diff[W-1:0];
        e.bout = (diff < 0);
        e.ovf  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        return e;
    endfunction

    // Drives a start for one edge; push=0 for operations that will be abandoned.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit push);
        x = a; y = b; bin = c; start = 1'b1;
        if (push) sb.push_back(model(a, b, c));
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for done, checking hold behaviour, latency and the popped result.
    task automatic wait_done(input string tag, input int exp_cycles);
        exp_t e;
        int   n = 0;
        while (!done && n < 20) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_hold"}, 32'({bout, d}), 32'({last_bout, last_d}));
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_cycles));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_D"}, 32'(d), 32'(e.d));
            check({tag, "_Bout"}, 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
            last_d    = e.d;
            last_bout = e.bout;
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_D", 32'(d), 32'd0);
        check("rst_Bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        tick();

        // Basic operations
        start_op(4'd9, 4'd3, 1'b0, 1'b1);
        wait_done("op9m3", W);
        tick();
        check("done_single", 32'(done), 32'd0);
        check("d_held", 32'(d), 32'd6);

        start_op(4'd3, 4'd9, 1'b0, 1'b1);
        wait_done("op3m9", W);
        start_op(4'd0, 4'd0, 1'b1, 1'b1);
        wait_done("op0m0b", W);
        tick();

        // Start while busy is ignored
        start_op(4'd5, 4'd2, 1'b0, 1'b1);
        x = 4'd1; y = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ign_start", W - 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ign_no_2nd_done", 32'(done), 32'd0);
            check("ign_idle", 32'(busy), 32'd0);
        end

        // Reset mid-operation
        start_op(4'd9, 4'd3, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_D", 32'(d), 32'd0);
        check("midrst_Bout", 32'(bout), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        last_d = '0; last_bout = 1'b0;
        for (int i = 0; i < W + 1; i++) begin
            tick();
            check("midrst_no_done", 32'(done), 32'd0);
        end
        start_op(4'd8, 4'd8, 1'b0, 1'b1);
        wait_done("op8m8", W);
        tick();

        // Back-to-back: start in the done cycle
        start_op(4'd9, 4'd3, 1'b0, 1'b1);
        wait_done("b2b_first", W);
        start_op(4'd2, 4'd7, 1'b0, 1'b1);
        check("b2b_accept", 32'(busy), 32'd1);
        check("b2b_D_kept", 32'(d), 32'd6);
        wait_done("b2b_second", W);
        tick();

`ifdef SERIAL_SUB_OVF_EN
        start_op(4'd7, 4'hF, 1'b0, 1'b1);
        wait_done("ovf_7mF", W);
        start_op(4'd4, 4'd2, 1'b0, 1'b1);
        wait_done("ovf_4m2", W);
`endif

        // Random operations
        for (int i = 0; i < 8; i++) begin
            start_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
            wait_done("rand", W);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing D = X - Y - Bin.
- Uses a single full-subtractor cell, one bit per clock, LSB first, with a borrow register carried between cycles.
- Counterpart to the parallel ripple-carry adder datapath: same operand format, opposite operation, area-minimal sequential form.
- Used where subtraction latency of WIDTH cycles is acceptable; start/busy/done handshake toward the controlling FSM.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock, only clock in the block
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only when idle
X  input  WIDTH  minuend, captured on the accepted start edge
Y  input  WIDTH  subtrahend, captured on the accepted start edge
Bin  input  1  borrow-in, captured on the accepted start edge
busy  output  1  high while the operation is in progress
done  output  1  single-cycle pulse, result valid
D  output  WIDTH  difference, registered, held until the next result
Bout  output  1  final borrow-out, registered, held with D
ovf  output  1  signed overflow (only with SERIAL_SUB_OVF_EN)

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, D=0, Bout=0, ovf=0, bit counter=0, borrow reg=0. Reset overrides every other input on the same edge.
- Reset mid-operation: abandons the operation; no done pulse; outputs take reset values.
- FSM states: IDLE, SHIFT.
- IDLE, start=1 at edge E0:
  - Capture X, Y, Bin into shift/borrow registers.
  - Set count=0, busy=1, move to SHIFT.
  - Inputs are ignored at all other times.
- SHIFT, each edge processes bit i = count using x = Xreg[0], y = Yreg[0], b = borrow reg:
  - d = x^y^b
  - b' = (~x&y) | (~(x^y)&b)
  - d shifts into the result register from the MSB side.
  - Xreg and Yreg shift right by one; count increments.
- Edge E_WIDTH (last bit):
  - Load D from the completed result register; Bout = b'.
  - busy=0, done=1, return to IDLE.
- Latency: done high in the cycle following edge E_WIDTH, i.e. exactly WIDTH cycles after the start edge. Throughput: one operation per WIDTH+1 cycles minimum.
- done: high for exactly one cycle; cleared on the next edge unless a new operation completes.
- start while busy: ignored, no queueing; captured operands are unaffected.
- start in the done cycle: accepted (FSM is IDLE). D/Bout keep the previous result until the new one completes.
- D/Bout change only at completion; they are stable while busy.
- Arithmetic: result modulo 2^WIDTH. Bout=1 iff X < Y + Bin (unsigned), i.e. D + ... equals X - Y - Bin + Bout*2^WIDTH.
- Counter width: clog2(WIDTH)+1 bits; no wrap within an operation.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Port ovf exists; registered at completion alongside D.
  - ovf = (X[MSB]!=Y[MSB]) && (D[MSB]!=X[MSB]), two's-complement overflow, using the captured MSBs.
  - ovf is 0 on reset and held until the next completion.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4: X=9, Y=3, Bin=0, start pulse -> busy for 4 cycles, done in 5th cycle after start edge, D=6, Bout=0.
- WIDTH=4: X=3, Y=9, Bin=0 -> D=4'hA, Bout=1. Then X=0, Y=0, Bin=1 -> D=4'hF, Bout=1.
- Start X=5, Y=2; assert start again with X=1, Y=1 at busy cycle 2 -> second start ignored, D=3; done pulses once.
- Start X=9, Y=3; rst=1 at busy cycle 2 -> next cycle busy=0, D=0, Bout=0; no done pulse. New start X=8, Y=8 -> D=0, Bout=0.
- Back-to-back: start asserted in the done cycle of 9-3 with X=2, Y=7 -> accepted; D=6 held until the next done; then D=4'hB, Bout=1.
- SERIAL_SUB_OVF_EN, WIDTH=4: X=7, Y=4'hF -> D=4'h8, Bout=1, ovf=1. X=4, Y=2 -> ovf=0. WIDTH=8: X=200, Y=55 -> done after 8 cycles, D=145, Bout=0.
